// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction fetch/decode/execute sequencer with PC and retire counter.
// Optional single-step mode: define FETCH_SEQUENCER_SINGLE_STEP_EN to add the step input.
module fetch_sequencer #(
    parameter int ADDRESS_WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
    input  logic                     step,
`endif
    input  logic [15:0]              instr,
    output logic                     IR_Write,
    output logic [ADDRESS_WIDTH-1:0] addr,
    output logic                     ALU_En,
    output logic                     Reg_Write,
    output logic                     halted,
    output logic [2:0]               state,
    output logic [7:0]               retired
);

    // state     | meaning
    // IDLE      | waiting for run (or step) to start an instruction
    // FETCH     | instruction register loads from addr
    // DECODE    | opcode inspected, instruction copy captured
    // EXECUTE   | ALU strobe for ALU-class opcodes
    // WRITEBACK | register write, PC update, retire
    // HALT      | sticky stop, left only through reset
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]               retired_q, retired_d;
    logic [15:0]              instr_q, instr_d;

    logic       start_instr;
    logic       continue_run;
    logic [3:0] live_op;
    logic [3:0] held_op;

`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
    // One instruction per step pulse; run has no effect in this build.
    logic unused_run;
    assign unused_run   = run;
    assign start_instr  = step;
    assign continue_run = 1'b0;
`else
    assign start_instr  = run;
    assign continue_run = run;
`endif

    assign live_op = instr[15:12];
    assign held_op = instr_q[15:12];

    logic unused_instr_bits;
    assign unused_instr_bits = ^instr_q[11:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            retired_q <= '0;
            instr_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            retired_q <= retired_d;
            instr_q   <= instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_instr) state_d = S_FETCH;
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (live_op == OP_HALT)
                    state_d = S_HALT;
                else if (live_op == OP_NOP || live_op == OP_JMP)
                    state_d = S_WRITEBACK;
                else
                    state_d = S_EXECUTE;
            end
            S_EXECUTE: state_d = S_WRITEBACK;
            S_WRITEBACK: begin
                state_d = continue_run ? S_FETCH : S_IDLE;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // PC and retire count only move on the WRITEBACK exit, so addr is frozen
    // for the whole instruction and a reset beforehand discards it cleanly.
    always_comb begin
        instr_d   = instr_q;
        addr_d    = addr_q;
        retired_d = retired_q;
        if (state_q == S_DECODE) begin
            instr_d = instr;
        end
        if (state_q == S_WRITEBACK) begin
            retired_d = retired_q + 8'd1;
            if (held_op == OP_JMP)
                addr_d = {instr_q[ADDRESS_WIDTH-1:1], 1'b0};
            else
                addr_d = addr_q + ADDRESS_WIDTH'(2);
        end
    end

    always_comb begin
        IR_Write  = 1'b0;
        ALU_En    = 1'b0;
        Reg_Write = 1'b0;
        halted    = 1'b0;
        case (state_q)
            S_FETCH:     IR_Write = 1'b1;
            S_EXECUTE:   ALU_En   = 1'b1;
            S_WRITEBACK: Reg_Write = (held_op != OP_NOP) && (held_op != OP_JMP) &&
                                     (held_op != OP_HALT);
            S_HALT:      halted   = 1'b1;
            default: ;
        endcase
    end

    assign addr    = addr_q;
    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a program-level reference model queues the
// expected per-instruction behaviour and a monitor checks it cycle by cycle.
module tb_fetch_sequencer;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          run;
    logic [15:0]   instr;
    logic          IR_Write;
    logic [AW-1:0] addr;
    logic          ALU_En;
    logic          Reg_Write;
    logic          halted;
    logic [2:0]    state;
    logic [7:0]    retired;
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
    logic          step;
`endif

    fetch_sequencer #(.ADDRESS_WIDTH(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
        .step      (step),
`endif
        .instr     (instr),
        .IR_Write  (IR_Write),
        .addr      (addr),
        .ALU_En    (ALU_En),
        .Reg_Write (Reg_Write),
        .halted    (halted),
        .state     (state),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    // Instruction memory indexed by byte address; after DECODE the live bus
    // carries junk so the design must rely on its own copy of the instruction.
    logic [15:0] imem [0:7];
    logic        glitch = 1'b0;
    logic        glitch_en = 1'b1;
    logic [15:0] junk = 16'h0;
    assign instr = glitch ? junk : imem[addr];

    typedef struct {
        int pc;
        int len;
        bit rw;
        int ret;
        bit halt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    bit   active = 1'b0;
    bit   halt_seen = 1'b0;
    int   start_cyc = 0;
    int   model_pc;
    int   model_ret;
    bit   model_halt;

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp_v);
        end
    endtask

    // Reference model: walk the program from pc 0 and record how each
    // instruction must look from the outside.
    task automatic run_model(input int n);
        int pc;
        int ret;
        int op;
        exp_t e;
        pc = 0;
        ret = 0;
        model_halt = 1'b0;
        for (int i = 0; i < n; i++) begin
            op = int'(imem[pc][15:12]);
            e.pc = pc;
            e.ret = ret;
            if (op == 15) begin
                e.halt = 1'b1;
                e.len = 3;
                e.rw = 1'b0;
                sb.push_back(e);
                model_halt = 1'b1;
                break;
            end
            e.halt = 1'b0;
            e.len = (op == 0 || op == 14) ? 3 : 4;
            e.rw = (op >= 1 && op <= 13);
            sb.push_back(e);
            ret = (ret + 1) % 256;
            pc = (op == 14) ? int'(imem[pc] & 16'h0006) : (pc + 2) % 8;
        end
        model_pc = pc;
        model_ret = ret;
    endtask

    exp_t mon_e;
    int   mon_k;
    int   mon_st;

    always @(negedge clk) begin
        cyc++;
        if (!mon_en) begin
            active = 1'b0;
        end else begin
            if (!active && state == 3'd1) begin
                if (sb.size() == 0) check("unexpected_fetch", 1, 0);
                else begin
                    active = 1'b1;
                    start_cyc = cyc;
                end
            end
            if (active) begin
                mon_e = sb[0];
                mon_k = cyc - start_cyc;
                if (mon_e.halt) mon_st = (mon_k == 0) ? 1 : (mon_k == 1) ? 2 : 5;
                else if (mon_e.len == 4) mon_st = mon_k + 1;
                else mon_st = (mon_k == 2) ? 4 : mon_k + 1;
                check("state", int'(state), mon_st);
                check("addr", int'(addr), mon_e.pc);
                check("retired", int'(retired), mon_e.ret);
                check("IR_Write", int'(IR_Write), int'(mon_k == 0));
                check("ALU_En", int'(ALU_En), int'(!mon_e.halt && mon_e.len == 4 && mon_k == 2));
                check("Reg_Write", int'(Reg_Write),
                      int'(!mon_e.halt && mon_e.rw && mon_k == mon_e.len - 1));
                check("halted", int'(halted), int'(mon_e.halt && mon_k == 2));
                if (mon_k >= mon_e.len - 1) begin
                    void'(sb.pop_front());
                    active = 1'b0;
                    if (mon_e.halt) halt_seen = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        #2;
        glitch = glitch_en && (state == 3'd3 || state == 3'd4);
        junk = 16'($urandom);
    end

    task automatic do_reset(input bit run_val);
        mon_en = 1'b0;
        sb.delete();
        halt_seen = 1'b0;
        run = run_val;
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
        step = 1'b0;
`endif
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_state", int'(state), 0);
        check("rst_addr", int'(addr), 0);
        check("rst_retired", int'(retired), 0);
        check("rst_strobes", int'({IR_Write, ALU_En, Reg_Write, halted}), 0);
    endtask

    function automatic logic [15:0] rand_instr(input bit allow_halt);
        int op;
        if (allow_halt && $urandom_range(0, 7) == 0) op = 15;
        else op = $urandom_range(0, 14);
        return {4'(op), 12'($urandom)};
    endfunction

    // Start a program with run high and drop run during the n-th FETCH,
    // so the last instruction finishes with run already low.
    task automatic run_phase(input int n, input bit run_in_reset);
        int fetches;
        int budget;
        do_reset(run_in_reset);
        run_model(n);
        mon_en = 1'b1;
        reset = 1'b0;
        if (!run_in_reset) begin
            repeat (3) @(negedge clk);
            #1;
            check("idle_wait", int'(state), 0);
            run = 1'b1;
        end
        fetches = 0;
        budget = 5 * n + 20;
        while (budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
            if (state == 3'd1) begin
                fetches++;
                if (fetches >= n) run = 1'b0;
            end
            if (model_halt ? halt_seen : (sb.size() == 0 && !active)) break;
        end
        if (budget == 0) check("timeout", 1, 0);
        if (model_halt) begin
            for (int i = 0; i < 20; i++) begin
                run = ~run;
                @(negedge clk);
                #1;
                check("halt_sticky", int'(state), 5);
                check("halt_addr", int'(addr), model_pc);
                check("halt_retired", int'(retired), model_ret);
            end
        end else begin
            repeat (3) @(negedge clk);
            #1;
            check("end_idle", int'(state), 0);
            check("end_addr", int'(addr), model_pc);
            check("end_retired", int'(retired), model_ret);
        end
    endtask

    initial begin
        reset = 1'b1;
        run = 1'b0;
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
        step = 1'b0;
        for (int i = 0; i < 8; i++) imem[i] = 16'h1000 | 16'(i);
        do_reset(1'b1);
        run_model(3);
        mon_en = 1'b1;
        reset = 1'b0;
        for (int p = 0; p < 3; p++) begin
            repeat (2) @(negedge clk);
            #1;
            check("step_idle", int'(state), 0);
            step = 1'b1;
            @(negedge clk);
            #1;
            step = 1'b0;
            for (int t = 0; t < 10 && state != 3'd0; t++) begin
                @(negedge clk);
                #1;
            end
            check("step_back_idle", int'(state), 0);
        end
        repeat (3) @(negedge clk);
        #1;
        check("step_addr", int'(addr), 6);
        check("step_retired", int'(retired), 3);
        check("step_queue", sb.size(), 0);
`else
        for (int i = 0; i < 8; i++) imem[i] = 16'h2000;
        imem[0] = 16'h1234;
        run_phase(1, 1'b1);

        for (int i = 0; i < 8; i++) imem[i] = 16'h2000 | 16'(i);
        run_phase(4, 1'b1);
        check("alu4_wrap_addr", int'(addr), 0);

        for (int i = 0; i < 8; i++) imem[i] = 16'h3000;
        imem[0] = 16'hE005;
        imem[4] = 16'h0000;
        run_phase(2, 1'b0);

        imem[0] = 16'h1000;
        imem[2] = 16'hF000;
        run_phase(5, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("halt_exit_state", int'(state), 0);
        check("halt_exit_addr", int'(addr), 0);

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 8; i++) imem[i] = rand_instr(r >= 4);
            run_phase($urandom_range(3, 24), r[0]);
        end

        for (int i = 0; i < 8; i++) imem[i] = rand_instr(1'b0);
        run_phase(260, 1'b1);

        // Reset while the third ALU instruction is executing.
        for (int i = 0; i < 8; i++) imem[i] = 16'h3000;
        do_reset(1'b1);
        reset = 1'b0;
        begin
            int t;
            t = 0;
            while (!(state == 3'd3 && addr == 3'd4) && t < 40) begin
                @(negedge clk);
                #1;
                t++;
            end
            check("reach_exec_addr4", int'(t < 40), 1);
        end
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("midexec_state", int'(state), 0);
        check("midexec_addr", int'(addr), 0);
        check("midexec_retired", int'(retired), 0);
        check("midexec_regwrite", int'(Reg_Write), 0);
        reset = 1'b0;
        run = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("midexec_idle", int'(state), 0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
